// File: rtl/module_display_7seg.sv
// Four-digit multiplexed 7-segment driver with frame-synchronous digit update.
// Optional leading-zero blanking is enabled by defining BLANK_LEADING_ZEROS_EN.
module module_display_7seg #(
    parameter int unsigned REFRESH_DIV = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] unidades_input,
    input  logic [3:0] decenas_input,
    input  logic [3:0] centenas_input,
    input  logic [3:0] millares_input,
    input  logic       listo,
    output logic [3:0] anodo_output,
    output logic [6:0] segmentos_output,
    output logic       cuadro_output
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    pend_u, pend_d, pend_c, pend_m;
    logic [3:0]    disp_u, disp_d, disp_c, disp_m;
    logic          tc;
    logic          blank1, blank2, blank3;
    logic [3:0]    cur_digit;
    logic          cur_blank;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'b1000000;
            4'd1:    seg_enc = 7'b1111001;
            4'd2:    seg_enc = 7'b0100100;
            4'd3:    seg_enc = 7'b0110000;
            4'd4:    seg_enc = 7'b0011001;
            4'd5:    seg_enc = 7'b0010010;
            4'd6:    seg_enc = 7'b0000010;
            4'd7:    seg_enc = 7'b1111000;
            4'd8:    seg_enc = 7'b0000000;
            4'd9:    seg_enc = 7'b0010000;
            default: seg_enc = 7'b0111111;
        endcase
    endfunction

    assign tc = (cnt == CNT_MAX);

    // A digit only blanks when every more-significant digit is also zero; dashes count as nonzero.
`ifdef BLANK_LEADING_ZEROS_EN
    assign blank3 = (disp_m == 4'd0);
    assign blank2 = blank3 && (disp_c == 4'd0);
    assign blank1 = blank2 && (disp_d == 4'd0);
`else
    assign blank3 = 1'b0;
    assign blank2 = 1'b0;
    assign blank1 = 1'b0;
`endif

    always_comb begin
        cur_digit = disp_u;
        cur_blank = 1'b0;
        an_next   = 4'b1110;
        case (state)
            DIG0: begin cur_digit = disp_u; cur_blank = 1'b0;   an_next = 4'b1110; end
            DIG1: begin cur_digit = disp_d; cur_blank = blank1; an_next = 4'b1101; end
            DIG2: begin cur_digit = disp_c; cur_blank = blank2; an_next = 4'b1011; end
            DIG3: begin cur_digit = disp_m; cur_blank = blank3; an_next = 4'b0111; end
            default: ;
        endcase
        seg_next = cur_blank ? 7'b1111111 : seg_enc(cur_digit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= DIG0;
            cnt              <= '0;
            pend_u           <= '0;
            pend_d           <= '0;
            pend_c           <= '0;
            pend_m           <= '0;
            disp_u           <= '0;
            disp_d           <= '0;
            disp_c           <= '0;
            disp_m           <= '0;
            anodo_output     <= '1;
            segmentos_output <= '1;
            cuadro_output    <= 1'b0;
        end else begin
            cnt              <= tc ? '0 : cnt + 1'b1;
            anodo_output     <= an_next;
            segmentos_output <= seg_next;
            cuadro_output    <= tc && (state == DIG3);

            if (listo) begin
                pend_u <= unidades_input;
                pend_d <= decenas_input;
                pend_c <= centenas_input;
                pend_m <= millares_input;
            end

            if (tc) begin
                case (state)
                    DIG0: state <= DIG1;
                    DIG1: state <= DIG2;
                    DIG2: state <= DIG3;
                    default: begin
                        state <= DIG0;
                        // Bypass pend_* so a strobe on the boundary edge is not a frame late.
                        if (listo) begin
                            disp_u <= unidades_input;
                            disp_d <= decenas_input;
                            disp_c <= centenas_input;
                            disp_m <= millares_input;
                        end else begin
                            disp_u <= pend_u;
                            disp_d <= pend_d;
                            disp_c <= pend_c;
                            disp_m <= pend_m;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_module_display_7seg.sv
// Directed bench for module_display_7seg with REFRESH_DIV = 4 (16-cycle frame).
module tb_module_display_7seg;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] unidades_input, decenas_input, centenas_input, millares_input;
    logic       listo;
    logic [3:0] anodo_output;
    logic [6:0] segmentos_output;
    logic       cuadro_output;

    int unsigned total = 0;
    int unsigned bad   = 0;

`ifdef BLANK_LEADING_ZEROS_EN
    localparam logic [6:0] LEAD_ZERO = 7'b1111111;
`else
    localparam logic [6:0] LEAD_ZERO = 7'b1000000;
`endif

    module_display_7seg #(.REFRESH_DIV(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .unidades_input   (unidades_input),
        .decenas_input    (decenas_input),
        .centenas_input   (centenas_input),
        .millares_input   (millares_input),
        .listo            (listo),
        .anodo_output     (anodo_output),
        .segmentos_output (segmentos_output),
        .cuadro_output    (cuadro_output)
    );

    always #5 clk = ~clk;

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] seg);
        check({tag, "_an"},  {4'h0, anodo_output},     {4'h0, an});
        check({tag, "_seg"}, {1'b0, segmentos_output}, {1'b0, seg});
    endtask

    task automatic chk_cuadro(input string tag, input logic exp);
        check(tag, {7'h0, cuadro_output}, {7'h0, exp});
    endtask

    task automatic set_digits(input logic [3:0] m, c, d, u);
        millares_input = m;
        centenas_input = c;
        decenas_input  = d;
        unidades_input = u;
    endtask

    initial begin
        // Reset held with a live strobe: nothing may be captured.
        rst = 1'b0;
        listo = 1'b1;
        set_digits(4'd9, 4'd9, 4'd9, 4'd9);
        tick(3);
        chk_out("reset", 4'b1111, 7'b1111111);
        chk_cuadro("reset_cuadro", 1'b0);
        listo = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        @(negedge clk) rst = 1'b1;

        // Idle scan after release (E1..E17)
        tick(1);  chk_out("e1_dig0", 4'b1110, 7'b1000000);
        chk_cuadro("e1_cuadro", 1'b0);
        tick(4);  chk_out("e5_dig1", 4'b1101, 7'b1000000);
        tick(4);  chk_out("e9_dig2", 4'b1011, 7'b1000000);
        tick(4);  chk_out("e13_dig3", 4'b0111, 7'b1000000);
        tick(3);  chk_cuadro("e16_cuadro", 1'b1);
        tick(1);  chk_cuadro("e17_cuadro", 1'b0);
        chk_out("e17_dig0", 4'b1110, 7'b1000000);

        // Mid-frame strobe 1,2,3,4 captured at E18; current frame stays 0000
        listo = 1'b1;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        tick(1);
        listo = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        tick(3);  chk_out("e21_old", 4'b1101, 7'b1000000);
        tick(8);  chk_out("e29_old", 4'b0111, 7'b1000000);
        tick(3);  chk_cuadro("e32_cuadro", 1'b1);
        tick(1);  chk_out("e33_units4", 4'b1110, 7'b0011001);
        tick(4);  chk_out("e37_tens3", 4'b1101, 7'b0110000);
        tick(4);  chk_out("e41_hund2", 4'b1011, 7'b0100100);
        tick(4);  chk_out("e45_thou1", 4'b0111, 7'b1111001);

        // Strobe 9,8,7,6 exactly on the boundary edge E48
        tick(2);
        listo = 1'b1;
        set_digits(4'd9, 4'd8, 4'd7, 4'd6);
        tick(1);
        listo = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        chk_cuadro("e48_cuadro", 1'b1);
        chk_out("e48_thou1", 4'b0111, 7'b1111001);
        tick(1);  chk_out("e49_units6", 4'b1110, 7'b0000010);
        tick(4);  chk_out("e53_tens7", 4'b1101, 7'b1111000);
        tick(4);  chk_out("e57_hund8", 4'b1011, 7'b0000000);
        tick(4);  chk_out("e61_thou9", 4'b0111, 7'b0010000);

        // 0,0,0,5 captured at E62, shown from E65
        listo = 1'b1;
        set_digits(4'd0, 4'd0, 4'd0, 4'd5);
        tick(1);
        listo = 1'b0;
        tick(3);  chk_out("e65_units5", 4'b1110, 7'b0010010);
        tick(4);  chk_out("e69_tens0", 4'b1101, LEAD_ZERO);
        tick(4);  chk_out("e73_hund0", 4'b1011, LEAD_ZERO);
        tick(4);  chk_out("e77_thou0", 4'b0111, LEAD_ZERO);

        // 0,A,0,C captured at E78: dashes, and a dash stops leading-zero blanking
        listo = 1'b1;
        set_digits(4'd0, 4'hA, 4'd0, 4'hC);
        tick(1);
        listo = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        tick(3);  chk_out("e81_units_dash", 4'b1110, 7'b0111111);
        tick(4);  chk_out("e85_tens0", 4'b1101, 7'b1000000);
        tick(4);  chk_out("e89_hund_dash", 4'b1011, 7'b0111111);

        // Asynchronous reset while in DIG2
        #2 rst = 1'b0;
        #1 chk_out("async_rst", 4'b1111, 7'b1111111);
        chk_cuadro("async_rst_cuadro", 1'b0);
        @(negedge clk) rst = 1'b1;
        tick(1);  chk_out("rst2_e1", 4'b1110, 7'b1000000);
        tick(4);  chk_out("rst2_e5", 4'b1101, 7'b1000000);
        tick(12); chk_out("rst2_e17", 4'b1110, 7'b1000000);
        tick(4);  chk_out("rst2_e21", 4'b1101, 7'b1000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/module_display_7seg.md
MODULE_DISPLAY_7SEG -- requirements
Module: module_display_7seg

Interface
REQ-001 Parameter REFRESH_DIV, default 27000: number of clk cycles each digit stays active (>= 2).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; the block is in reset while rst = 0.
REQ-004 unidades_input  input  4  BCD units digit from the BCD converter.
REQ-005 decenas_input  input  4  BCD tens digit.
REQ-006 centenas_input  input  4  BCD hundreds digit.
REQ-007 millares_input  input  4  BCD thousands digit.
REQ-008 listo  input  1  digits-valid strobe; capture the four digit inputs on any clk edge where listo = 1.
REQ-009 anodo_output  output  4  digit enables, one-hot, active-low; bit 0 = units, bit 3 = thousands.
REQ-010 segmentos_output  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 cuadro_output  output  1  one-cycle pulse when a full 4-digit scan frame completes.

Function
REQ-012 The block SHALL hold two register sets: pending (pend_*) and displayed (disp_*), each 4 x 4 bits.
REQ-013 On each clk edge with listo = 1, the block SHALL load pend_* from the digit inputs; if listo stays high, it loads again on every such edge.
REQ-014 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; terminal count (TC) is counter = REFRESH_DIV-1.
REQ-015 Scan FSM states: DIG0 (units), DIG1 (tens), DIG2 (hundreds), DIG3 (thousands).
REQ-016 On TC, the FSM SHALL step DIG0->DIG1->DIG2->DIG3->DIG0; otherwise it SHALL hold its state.
REQ-017 On TC in DIG3 (frame boundary), disp_* SHALL load pend_* and cuadro_output SHALL pulse high for exactly one cycle.
REQ-018 If listo = 1 on the same edge as a frame boundary, disp_* SHALL load the digit inputs directly, and pend_* SHALL also load them.
REQ-019 disp_* SHALL never change except at a frame boundary (no mid-frame tearing).
REQ-020 anodo_output and segmentos_output SHALL be registered, driven one cycle after the FSM state they represent.
REQ-021 anodo_output SHALL be 4'b1110, 4'b1101, 4'b1011 or 4'b0111 for DIG0..DIG3 respectively.
REQ-022 Segment encoding (common anode): 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
REQ-023 A digit value of 10..15 SHALL display a dash, 0111111.
REQ-024 Blank SHALL be encoded 1111111.

Reset
REQ-025 While rst = 0, the block SHALL clear all counters: refresh counter = 0, FSM = DIG0, pend_* = 0, disp_* = 0.
REQ-026 While rst = 0, the outputs SHALL be anodo_output = 1111, segmentos_output = 1111111 and cuadro_output = 0.
REQ-027 Reset asserted mid-frame or mid-capture SHALL abort immediately with no partial update surviving.
REQ-028 On the first edge after rst rises, the block SHALL drive DIG0 and display 0 (1000000).

Configuration
REQ-029 Macro BLANK_LEADING_ZEROS_EN SHALL control leading-zero blanking, applied to disp_*.
REQ-030 With BLANK_LEADING_ZEROS_EN defined, thousands SHALL be blanked if it is 0.
REQ-031 With BLANK_LEADING_ZEROS_EN defined, hundreds SHALL be blanked if it and thousands are 0.
REQ-032 With BLANK_LEADING_ZEROS_EN defined, tens SHALL be blanked if it, hundreds and thousands are 0.
REQ-033 Units SHALL never be blanked.
REQ-034 With BLANK_LEADING_ZEROS_EN defined, a dash digit (10..15) SHALL count as nonzero.
REQ-035 Without BLANK_LEADING_ZEROS_EN, all four digits SHALL always be shown per REQ-022/023.

Verification (REFRESH_DIV = 4)
REQ-036 Reset release, no listo -> anodo cycles 1110,1101,1011,0111 every 4 clk; segmentos = 1000000 throughout; cuadro pulses every 16 clk.
REQ-037 listo pulse with digits 1,2,3,4 (thousands..units) mid-frame -> current frame still shows 0000; from the next frame DIG0 = 0011001 (4) and DIG3 = 1111001 (1).
REQ-038 listo coincident with the DIG3 TC edge, digits 9,8,7,6 -> next DIG0 shows 0000010 (6) with no extra frame delay.
REQ-039 Digits 0,0,0,5 with BLANK_LEADING_ZEROS_EN -> DIG3..DIG1 = 1111111 and DIG0 = 0010010; without the macro -> DIG3..DIG1 = 1000000.
REQ-040 Units input = 4'hC -> DIG0 = 0111111; rst pulled low in DIG2 -> outputs 1111/1111111 immediately and restart at DIG0 showing 0.
